// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver with a shared tick prescaler.
// Each channel runs OFF, ON, BLINK or BREATHE (triangular PWM duty ramp).
module led_pattern_gen #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1_000,
  parameter int N_CH     = 4,
  parameter int DIV_W    = 16,
  parameter int PWM_BITS = 8,
  parameter int RST_HALF = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [DIV_W-1:0]        cfg_half,
  output logic                    cfg_err,
  output logic                    tick_o,
  output logic [N_CH-1:0]         led
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_ON  = 2'd1;
  localparam logic [1:0] M_BLK = 2'd2;
  localparam logic [1:0] M_BRE = 2'd3;

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_err;
  logic                w_tick;

  assign w_tick  = (r_pre == PRE_LAST);
  assign tick_o  = w_tick;
  assign cfg_err = r_err;

  // Prescaler: 0..DIV-1, tick fires on the last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Shared free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + 1'b1;
    end
  end

  // Flag writes aimed at a channel that does not exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= cfg_wr && (32'(cfg_ch) >= N_CH);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]          r_mode;
    logic [DIV_W-1:0]    r_half;
    logic [DIV_W-1:0]    r_tcnt;
    logic                r_phase;
    logic                r_dir;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_led;
    logic                w_wr;
    logic                w_run;
    logic [DIV_W-1:0]    w_last;
    logic                w_evt;

    assign w_wr   = cfg_wr && (cfg_ch == CH_W'(g));
    assign w_run  = r_mode[1];
    assign w_last = (r_half == '0) ? '0 : r_half - 1'b1;
    assign w_evt  = w_tick && w_run && (r_tcnt == w_last);
    assign led[g] = r_led;

    // Channel state: config write restarts, events advance the pattern.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mode  <= M_OFF;
        r_half  <= DIV_W'(RST_HALF);
        r_tcnt  <= '0;
        r_phase <= 1'b0;
        r_dir   <= 1'b0;
        r_duty  <= '0;
      end else if (w_wr) begin
        r_mode  <= cfg_mode;
        r_half  <= cfg_half;
        r_tcnt  <= '0;
        r_phase <= 1'b0;
        r_dir   <= 1'b0;
        r_duty  <= '0;
      end else if (w_tick && w_run) begin
        if (w_evt) begin
          r_tcnt <= '0;
          if (r_mode == M_BLK) begin
            r_phase <= ~r_phase;
          end else if (!r_dir) begin
            if (r_duty == DUTY_MAX) r_dir <= 1'b1;
            else r_duty <= r_duty + 1'b1;
          end else begin
            if (r_duty == '0) r_dir <= 1'b0;
            else r_duty <= r_duty - 1'b1;
          end
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end
    end

    // Registered LED drive from the current mode.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_led <= 1'b0;
      end else begin
        unique case (r_mode)
          M_OFF:   r_led <= 1'b0;
          M_ON:    r_led <= 1'b1;
          M_BLK:   r_led <= r_phase;
          M_BRE:   r_led <= (r_pwm < r_duty);
          default: r_led <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed scenarios then random config traffic,
// checked each cycle against a tick-count based reference model.
module tb_led_pattern_gen;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int N_CH = 3;
  localparam int DIV_W = 16;
  localparam int PWM_BITS = 4;
  localparam int RST_HALF = 500;
  localparam int PWM_N = 1 << PWM_BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [DIV_W-1:0] cfg_half = '0;
  logic             cfg_err;
  logic             tick_o;
  logic [N_CH-1:0]  led;

  led_pattern_gen #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N_CH),
    .DIV_W(DIV_W), .PWM_BITS(PWM_BITS), .RST_HALF(RST_HALF)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_err(cfg_err),
    .tick_o(tick_o), .led(led)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per channel, ticks seen since last restart.
  int c = 0;
  int m_mode[N_CH];
  int m_half[N_CH];
  int m_ticks[N_CH];
  logic [N_CH-1:0] exp_led = '0;
  logic exp_err = 1'b0;
  bit armed = 1'b0;

  function automatic int hper(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  function automatic int duty_of(input int k);
    int p;
    p = k % (2 * PWM_N);
    return (p < PWM_N) ? p : 2 * PWM_N - 1 - p;
  endfunction

  function automatic logic led_of(input int mode, input int half,
                                  input int ticks, input int cc);
    int k;
    k = ticks / hper(half);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return logic'(k % 2);
      default: return (cc % PWM_N) < duty_of(k);
    endcase
  endfunction

  always @(posedge clk) begin
    bit tk;
    armed = 1'b1;
    if (rst) begin
      c = 0;
      exp_led = '0;
      exp_err = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 0;
        m_half[i] = RST_HALF;
        m_ticks[i] = 0;
      end
    end else begin
      tk = (c % DIV) == DIV - 1;
      for (int i = 0; i < N_CH; i++)
        exp_led[i] = led_of(m_mode[i], m_half[i], m_ticks[i], c);
      exp_err = cfg_wr && (int'(cfg_ch) >= N_CH);
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_wr && int'(cfg_ch) == i) begin
          m_mode[i] = int'(cfg_mode);
          m_half[i] = int'(cfg_half);
          m_ticks[i] = 0;
        end else if (tk && m_mode[i] >= 2) begin
          m_ticks[i]++;
        end
      end
      c++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("led", 32'(led), 32'(exp_led));
      check("tick_o", 32'(tick_o), 32'((c % DIV) == DIV - 1));
      check("cfg_err", 32'(cfg_err), 32'(exp_err));
    end
  end

  task automatic wr(input int ch, input int mode, input int half);
    cfg_wr = 1'b1;
    cfg_ch = 2'(ch);
    cfg_mode = 2'(mode);
    cfg_half = DIV_W'(half);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  initial begin
    bit found;
    int r;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(negedge clk);

    wr(0, 2, 3);
    repeat (200) @(negedge clk);
    wr(1, 3, 1);
    repeat (750) @(negedge clk);

    wr(2, 1, 9);
    repeat (4) @(negedge clk);
    wr(2, 0, 9);
    repeat (10) @(negedge clk);

    wr(3, 2, 7);
    repeat (10) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((c % DIV) == DIV - 1 && m_mode[0] == 2 &&
          ((m_ticks[0] + 1) % hper(m_half[0])) == 0)
        found = 1'b1;
      else
        @(negedge clk);
    end
    check("evt_wait", 32'(found), 32'd1);
    wr(0, 2, 3);
    repeat (20) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode[0] == 2 && ((m_ticks[0] / hper(m_half[0])) % 2) == 1)
        found = 1'b1;
      else
        @(negedge clk);
    end
    check("phase_wait", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    wr(0, 2, 2);
    wr(1, 3, 1);
    wr(2, 2, 0);
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 99));
      cfg_wr = (r < 3);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_half = DIV_W'($urandom_range(0, 5));
      rst = (r == 99) && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    cfg_wr = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
